// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared types and helpers for the bit-serial adder.
//   - state_t     : controller states (IDLE, RUN, DONE)
//   - count_width : bit width of the bit-position counter for a given WIDTH
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter has to hold values 0..WIDTH, so it needs $clog2(WIDTH+1) bits.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   1-bit full adder cell, used as the datapath of the bit-serial adder.
//   Ports:
//     a, b, cin  in   addend bits and carry in
//     sum        out  a ^ b ^ cin
//     cout       out  majority(a, b, cin)
// -----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder. An operand pair is accepted over a valid/ready
//   handshake, shifted LSB-first through one full_adder cell with a registered
//   carry, and the WIDTH-bit sum plus carry-out are returned over a second
//   valid/ready handshake. One operation at a time, no overlap.
//
//   Parameters:
//     WIDTH      operand/sum width in bits (>= 1)
//   Ports:
//     clk        clock, rising edge
//     rst_n      synchronous active-low reset
//     in_valid   operand pair valid          in_ready   block can accept
//     a, b       operands (WIDTH)            cin        carry into bit 0
//     out_valid  result valid                out_ready  consumer takes result
//     sum        a + b + cin, low WIDTH bits cout       carry out of bit WIDTH-1
//     ovf        two's-complement overflow (only with SERIAL_ADDER_OVF_EN)
//
//   Build option:
//     SERIAL_ADDER_OVF_EN  adds the ovf output and its capture register.
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = count_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_next;
    logic             carry;
    logic [CW-1:0]    count;
    logic             load;
    logic             step;
    logic             last;
    logic             cell_sum;
    logic             cell_cout;

    full_adder u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (cell_sum),
        .cout (cell_cout)
    );

    assign last = (count == LAST_BIT);

    // Shift right and drop the new sum bit in at the MSB. Written as two steps
    // so the same code stays legal for WIDTH == 1.
    always_comb begin
        sum_next            = sum_sh >> 1;
        sum_next[WIDTH-1]   = cell_sum;
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            count  <= '0;
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            count <= '0;
        end else if (step) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= sum_next;
            carry  <= cell_cout;
            count  <= count + CW'(1);
        end
    end

    // In DONE the carry flop holds the carry out of the top bit and sum_sh the
    // full sum; neither changes until the next load.
    assign sum  = sum_sh;
    assign cout = carry;

`ifdef SERIAL_ADDER_OVF_EN
    // During the final RUN cycle the carry flop holds the carry into the MSB.
    logic carry_msb;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry_msb <= 1'b0;
        end else if (step && last) begin
            carry_msb <= carry;
        end
    end

    assign ovf = carry_msb ^ carry;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Directed testbench for serial_adder: one WIDTH=8 instance and one WIDTH=1
//   instance. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;

    // WIDTH = 8 instance
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    // WIDTH = 1 instance
    logic       in_valid1;
    logic       in_ready1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       out_valid1;
    logic       out_ready1;
    logic [0:0] sum1;
    logic       cout1;
    logic       ovf1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .cout      (cout1)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf1)
`endif
    );

`ifndef SERIAL_ADDER_OVF_EN
    assign ovf  = 1'b0;
    assign ovf1 = 1'b0;
`endif

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation on the WIDTH=8 instance from IDLE. lat counts edges
    // from the accepting edge (inclusive) to the one after which out_valid is seen.
    task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                         output logic [7:0] s, output logic c, output logic o,
                         output int lat);
        in_valid = 1'b1;
        a        = ia;
        b        = ib;
        cin      = ic;
        tick();
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        s         = sum;
        c         = cout;
        o         = ovf;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        n_cmp++;
        if (sum !== 8'h00 || cout !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_sum_cout: got %h/%b want 00/0", sum, cout);
        end
    endtask

    task automatic test_basic();
        logic [7:0] s;
        logic       c;
        logic       o;
        int         lat;
        do_op(8'h5A, 8'h3C, 1'b0, s, c, o, lat);
        n_cmp++;
        if (lat !== 9) begin
            n_bad++;
            $display("FAIL basic_latency: got %0d edges want 9", lat);
        end
        n_cmp++;
        if (s !== 8'h96 || c !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_5A_3C: got %h/%b want 96/0", s, c);
        end
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_release: got ov=%b ir=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_carry();
        logic [7:0] s;
        logic       c;
        logic       o;
        int         lat;
        do_op(8'hFF, 8'h01, 1'b0, s, c, o, lat);
        n_cmp++;
        if (s !== 8'h00 || c !== 1'b1) begin
            n_bad++;
            $display("FAIL carry_FF_01: got %h/%b want 00/1", s, c);
        end
        do_op(8'hFF, 8'h00, 1'b1, s, c, o, lat);
        n_cmp++;
        if (s !== 8'h00 || c !== 1'b1) begin
            n_bad++;
            $display("FAIL carry_FF_00_cin: got %h/%b want 00/1", s, c);
        end
    endtask

    // 0x12 + 0x34 + 1 = 0x47; garbage pulses in RUN/DONE must not disturb it.
    task automatic test_hold();
        int lat;
        in_valid = 1'b1;
        a        = 8'h12;
        b        = 8'h34;
        cin      = 1'b1;
        tick();
        a         = 8'hFF;
        b         = 8'hFF;
        out_ready = 1'b1;
        lat       = 1;
        while (!out_valid && lat < 40) begin
            in_valid = lat[0];
            tick();
            lat++;
        end
        n_cmp++;
        if (lat !== 9) begin
            n_bad++;
            $display("FAIL hold_latency: got %0d edges want 9", lat);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            n_cmp++;
            if (out_valid !== 1'b1 || sum !== 8'h47 || cout !== 1'b0 || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_cycle%0d: got ov=%b sum=%h cout=%b ir=%b want 1/47/0/0",
                         i, out_valid, sum, cout, in_ready);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_release: got ov=%b ir=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] s;
        logic       c;
        logic       o;
        int         lat;
        int         seen;
        in_valid = 1'b1;
        a        = 8'h80;
        b        = 8'h80;
        cin      = 1'b0;
        tick();                 // accept; now in RUN cycle 1
        in_valid = 1'b0;
        tick();                 // RUN cycle 2
        tick();                 // RUN cycle 3
        tick();                 // RUN cycle 4
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_cmp++;
        if (out_valid !== 1'b0 || sum !== 8'h00 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_state: got ov=%b sum=%h ir=%b want 0/00/1",
                     out_valid, sum, in_ready);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen++;
            tick();
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL midreset_no_result: got %0d valid cycles want 0", seen);
        end
        do_op(8'h33, 8'h44, 1'b1, s, c, o, lat);
        n_cmp++;
        if (s !== 8'h78 || c !== 1'b0 || lat !== 9) begin
            n_bad++;
            $display("FAIL midreset_next_op: got %h/%b lat=%0d want 78/0 lat=9", s, c, lat);
        end
    endtask

    // WIDTH=1, in_valid held high with out_ready high: accept, RUN, DONE, repeat.
    task automatic test_back_to_back();
        logic [2:0] vec [4];
        logic [1:0] exp [4];
        vec[0] = 3'b111; exp[0] = 2'b11;   // {a,b,cin} -> {cout,sum}
        vec[1] = 3'b100; exp[1] = 2'b01;
        vec[2] = 3'b001; exp[2] = 2'b01;
        vec[3] = 3'b011; exp[3] = 2'b10;
        in_valid1  = 1'b1;
        out_ready1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a1[0] = vec[k][2];
            b1[0] = vec[k][1];
            cin1  = vec[k][0];
            n_cmp++;
            if (in_ready1 !== 1'b1) begin
                n_bad++;
                $display("FAIL b2b_idle%0d: got ir=%b want 1", k, in_ready1);
            end
            tick();
            a1[0] = ~vec[k][2];
            b1[0] = ~vec[k][1];
            cin1  = ~vec[k][0];
            n_cmp++;
            if (in_ready1 !== 1'b0 || out_valid1 !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b_run%0d: got ir=%b ov=%b want 0/0", k, in_ready1, out_valid1);
            end
            tick();
            n_cmp++;
            if (out_valid1 !== 1'b1 || in_ready1 !== 1'b0 ||
                {cout1, sum1[0]} !== exp[k]) begin
                n_bad++;
                $display("FAIL b2b_result%0d: got ov=%b ir=%b cout/sum=%b%b want 1/0/%b",
                         k, out_valid1, in_ready1, cout1, sum1[0], exp[k]);
            end
            tick();
        end
        in_valid1  = 1'b0;
        out_ready1 = 1'b0;
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    task automatic test_ovf();
        logic [7:0] s;
        logic       c;
        logic       o;
        int         lat;
        do_op(8'h7F, 8'h01, 1'b0, s, c, o, lat);
        n_cmp++;
        if (s !== 8'h80 || c !== 1'b0 || o !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_7F_01: got %h/%b ovf=%b want 80/0 ovf=1", s, c, o);
        end
        do_op(8'hFF, 8'h01, 1'b0, s, c, o, lat);
        n_cmp++;
        if (s !== 8'h00 || c !== 1'b1 || o !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_FF_01: got %h/%b ovf=%b want 00/1 ovf=0", s, c, o);
        end
        do_op(8'h80, 8'h80, 1'b0, s, c, o, lat);
        n_cmp++;
        if (s !== 8'h00 || c !== 1'b1 || o !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_80_80: got %h/%b ovf=%b want 00/1 ovf=1", s, c, o);
        end
    endtask
`endif

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        cin        = 1'b0;
        out_ready  = 1'b0;
        in_valid1  = 1'b0;
        a1         = '0;
        b1         = '0;
        cin1       = 1'b0;
        out_ready1 = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_carry();
        test_hold();
        test_mid_reset();
        test_back_to_back();
`ifdef SERIAL_ADDER_OVF_EN
        test_ovf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
